// File: rtl/cpu_mem_responder.sv
// 68030 bus responder for the on-card 1 MB window (lower half SRAM, upper half ROM).
// Define RESPONDER_BERR_EN to bus-error ROM writes instead of silently discarding them.
module cpu_mem_responder #(
   parameter logic [11:0] WINDOW_BASE = 12'h000,
   parameter logic [3:0]  RAM_WS      = 4'd0,
   parameter logic [3:0]  ROM_WS      = 4'd2
) (
   input  logic        cpuClock,
   input  logic        cpuReset,
   input  logic        ncpuAS,
   input  logic        ncpuDS,
   input  logic        cpuRnW,
   input  logic [1:0]  cpuSize,
   input  logic [1:0]  cpuA,
   input  logic [12:0] cpuAddrHi,
   input  logic [2:0]  cpuFC,
   output logic        ncpuDsack0,
   output logic        ncpuDsack1,
   output logic        ncpuBerr,
   output logic        nmemCe,
   output logic        nramSel,
   output logic        nromSel,
   output logic        nmemOe,
   output logic [3:0]  nmemWe
);

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_WAIT = 3'd1,
      ST_ACK  = 3'd2,
      ST_ERR  = 3'd3,
      ST_DONE = 3'd4
   } state_t;

   state_t      r_state;
   state_t      w_stateNext;
   logic [3:0]  r_count;
   logic [3:0]  w_countNext;
   logic        r_isRom;
   logic        w_isRomNext;
   logic        r_isRead;
   logic        w_isReadNext;

   logic        w_hit;
   logic [3:0]  w_ws;
   logic        w_active;
   logic [3:0]  w_lane;
   logic        w_a1;
   logic        w_a0;
   logic        w_s1;
   logic        w_s0;

   // CPU-space cycles (FC = 7) never hit, so FPU/interrupt-ack traffic is ignored.
   assign w_hit = ~ncpuAS & (cpuFC != 3'h7) & (cpuAddrHi[12:1] == WINDOW_BASE);
   assign w_ws  = cpuAddrHi[0] ? ROM_WS : RAM_WS;

   always_ff @(posedge cpuClock or posedge cpuReset) begin
      if (cpuReset) begin
         r_state  <= ST_IDLE;
         r_count  <= 4'd0;
         r_isRom  <= 1'b0;
         r_isRead <= 1'b1;
      end else begin
         r_state  <= w_stateNext;
         r_count  <= w_countNext;
         r_isRom  <= w_isRomNext;
         r_isRead <= w_isReadNext;
      end
   end

   always_comb begin
      w_stateNext  = r_state;
      w_countNext  = r_count;
      w_isRomNext  = r_isRom;
      w_isReadNext = r_isRead;
      case (r_state)
         ST_IDLE: begin
            if (w_hit) begin
               w_isRomNext  = cpuAddrHi[0];
               w_isReadNext = cpuRnW;
`ifdef RESPONDER_BERR_EN
               if (cpuAddrHi[0] & ~cpuRnW) begin
                  w_stateNext = ST_ERR;
               end else
`endif
               if (w_ws == 4'd0) begin
                  w_stateNext = ST_ACK;
               end else begin
                  w_countNext = w_ws - 4'd1;
                  w_stateNext = ST_WAIT;
               end
            end
         end
         ST_WAIT: begin
            // An AS negation here is an aborted cycle: drop out without terminating.
            if (ncpuAS) begin
               w_stateNext = ST_IDLE;
            end else if (r_count == 4'd0) begin
               w_stateNext = ST_ACK;
            end else begin
               w_countNext = r_count - 4'd1;
            end
         end
         ST_ACK, ST_ERR: begin
            if (ncpuAS) begin
               w_stateNext = ST_IDLE;
            end
         end
         default: begin
            w_stateNext = ST_IDLE;
         end
      endcase
   end

   assign w_a1 = cpuA[1];
   assign w_a0 = cpuA[0];
   assign w_s1 = cpuSize[1];
   assign w_s0 = cpuSize[0];

   // Standard 68030 dynamic bus sizing lane decode for a 32-bit port.
   assign w_lane[3] = ~w_a1 & ~w_a0;
   assign w_lane[2] = ~w_a1 & (w_a0 | ~w_s0 | w_s1);
   assign w_lane[1] = (w_a1 & ~w_a0) | (~w_a1 & ~w_s0 & ~w_s1) |
                      (~w_a1 & w_s1 & w_s0) | (~w_a1 & w_a0 & ~w_s0);
   assign w_lane[0] = (w_a1 & w_a0) | (w_a0 & w_s0 & w_s1) |
                      (~w_s0 & ~w_s1) | (w_a1 & ~w_s0);

   assign w_active = (r_state == ST_WAIT) | (r_state == ST_ACK);

   assign ncpuDsack0 = ~(r_state == ST_ACK);
   assign ncpuDsack1 = ~(r_state == ST_ACK);
`ifdef RESPONDER_BERR_EN
   assign ncpuBerr   = ~(r_state == ST_ERR);
`else
   assign ncpuBerr   = 1'b1;
`endif
   assign nmemCe     = ~w_active;
   assign nramSel    = ~(w_active & ~r_isRom);
   assign nromSel    = ~(w_active & r_isRom);
   assign nmemOe     = ~(w_active & r_isRead);
   // Write strobes track DS live so they release before AS; ROM writes never strobe.
   assign nmemWe     = ~({4{w_active & ~r_isRead & ~r_isRom & ~ncpuDS}} & w_lane);

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Scoreboard bench for cpu_mem_responder: directed bus cycles push expected
// terminations, a negedge monitor pops and compares them.
module tb_cpu_mem_responder;

   logic        cpuClock = 1'b0;
   logic        cpuReset;
   logic        ncpuAS;
   logic        ncpuDS;
   logic        cpuRnW;
   logic [1:0]  cpuSize;
   logic [1:0]  cpuA;
   logic [12:0] cpuAddrHi;
   logic [2:0]  cpuFC;
   logic        ncpuDsack0;
   logic        ncpuDsack1;
   logic        ncpuBerr;
   logic        nmemCe;
   logic        nramSel;
   logic        nromSel;
   logic        nmemOe;
   logic [3:0]  nmemWe;

   localparam logic [10:0] IDLE_OUT = 11'h7FF;
   localparam logic [12:0] RAM_ADDR = 13'h0000;
   localparam logic [12:0] ROM_ADDR = 13'h0001;
   localparam logic [12:0] OUT_ADDR = 13'h0002;

   typedef struct {
      logic [10:0] resp;
      int          latency;
      int          hitEdge;
      string       name;
   } exp_t;

   exp_t scoreboard[$];
   int   testsRun    = 0;
   int   testsFailed = 0;
   int   edgeCount   = 0;
   logic prevTerm    = 1'b0;

   cpu_mem_responder #(
      .WINDOW_BASE(12'h000),
      .RAM_WS(4'd0),
      .ROM_WS(4'd2)
   ) dut (
      .cpuClock(cpuClock),
      .cpuReset(cpuReset),
      .ncpuAS(ncpuAS),
      .ncpuDS(ncpuDS),
      .cpuRnW(cpuRnW),
      .cpuSize(cpuSize),
      .cpuA(cpuA),
      .cpuAddrHi(cpuAddrHi),
      .cpuFC(cpuFC),
      .ncpuDsack0(ncpuDsack0),
      .ncpuDsack1(ncpuDsack1),
      .ncpuBerr(ncpuBerr),
      .nmemCe(nmemCe),
      .nramSel(nramSel),
      .nromSel(nromSel),
      .nmemOe(nmemOe),
      .nmemWe(nmemWe)
   );

   always #5 cpuClock = ~cpuClock;

   always @(posedge cpuClock) edgeCount++;

   // Output vector order: dsack1, dsack0, berr, ce, ramSel, romSel, oe, we[3:0]
   function automatic logic [10:0] packOut();
      return {ncpuDsack1, ncpuDsack0, ncpuBerr, nmemCe, nramSel, nromSel, nmemOe, nmemWe};
   endfunction

   function automatic logic [10:0] mkResp(input logic dsack, input logic berr, input logic ce,
                                          input logic ram, input logic rom, input logic oe,
                                          input logic [3:0] we);
      return {dsack, dsack, berr, ce, ram, rom, oe, we};
   endfunction

   // Monitor: on the first negedge of any termination, pop and compare.
   always @(negedge cpuClock) begin
      logic term;
      exp_t e;
      term = ~ncpuDsack0 | ~ncpuDsack1 | ~ncpuBerr;
      if (term && !prevTerm && !cpuReset) begin
         if (scoreboard.size() == 0) begin
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL unexpected_termination got=%b required=none", packOut());
         end else begin
            e = scoreboard.pop_front();
            testsRun++;
            if (packOut() !== e.resp) begin
               testsFailed++;
               $display("[TB] FAIL %s_resp got=%b required=%b", e.name, packOut(), e.resp);
            end
            testsRun++;
            if (edgeCount - e.hitEdge != e.latency) begin
               testsFailed++;
               $display("[TB] FAIL %s_latency got=%0d required=%0d", e.name,
                        edgeCount - e.hitEdge, e.latency);
            end
         end
      end
      prevTerm = term;
   end

   task automatic checkOutput(input string name, input logic [10:0] expected);
      testsRun++;
      if (packOut() !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s got=%b required=%b", name, packOut(), expected);
      end
   endtask

   task automatic waitTermination(input string name);
      bit done;
      done = 1'b0;
      for (int i = 0; i < 40 && !done; i++) begin
         @(negedge cpuClock);
         #1;
         if (~ncpuDsack0 | ~ncpuBerr) done = 1'b1;
      end
      if (!done) begin
         testsRun++;
         testsFailed++;
         $display("[TB] FAIL %s_timeout got=no termination required=termination", name);
      end
   endtask

   task automatic driveCycle(input logic [12:0] addrHi, input logic [2:0] fc, input logic rnw,
                             input logic [1:0] size, input logic [1:0] a);
      cpuAddrHi = addrHi;
      cpuFC     = fc;
      cpuRnW    = rnw;
      cpuSize   = size;
      cpuA      = a;
      ncpuAS    = 1'b0;
      ncpuDS    = 1'b0;
   endtask

   task automatic applyStimulus(input string name, input logic [12:0] addrHi, input logic [2:0] fc,
                                input logic rnw, input logic [1:0] size, input logic [1:0] a,
                                input logic [10:0] expResp, input int expLat);
      exp_t e;
      @(negedge cpuClock);
      #1;
      driveCycle(addrHi, fc, rnw, size, a);
      e.resp    = expResp;
      e.latency = expLat;
      e.hitEdge = edgeCount + 1;
      e.name    = name;
      scoreboard.push_back(e);
      waitTermination(name);
      ncpuAS = 1'b1;
      ncpuDS = 1'b1;
      @(posedge cpuClock);
      #1;
      checkOutput({name, "_idle"}, IDLE_OUT);
   endtask

   task automatic missCycle(input string name, input logic [12:0] addrHi, input logic [2:0] fc);
      logic [10:0] badVal;
      bit bad;
      bad    = 1'b0;
      badVal = IDLE_OUT;
      @(negedge cpuClock);
      #1;
      driveCycle(addrHi, fc, 1'b0, 2'b00, 2'b00);
      repeat (4) begin
         @(posedge cpuClock);
         #1;
         if (!bad && packOut() !== IDLE_OUT) begin
            bad    = 1'b1;
            badVal = packOut();
         end
      end
      ncpuAS = 1'b1;
      ncpuDS = 1'b1;
      testsRun++;
      if (bad) begin
         testsFailed++;
         $display("[TB] FAIL %s got=%b required=%b", name, badVal, IDLE_OUT);
      end
   endtask

   logic [1:0] laneA    [8] = '{2'b00, 2'b11, 2'b10, 2'b00, 2'b01, 2'b10, 2'b00, 2'b01};
   logic [1:0] laneSize [8] = '{2'b00, 2'b01, 2'b10, 2'b01, 2'b01, 2'b01, 2'b10, 2'b11};
   logic [3:0] laneWe   [8] = '{4'b0000, 4'b1110, 4'b1100, 4'b0111,
                                4'b1011, 4'b1101, 4'b0011, 4'b1000};

   initial begin
      cpuReset  = 1'b1;
      ncpuAS    = 1'b1;
      ncpuDS    = 1'b1;
      cpuRnW    = 1'b1;
      cpuSize   = 2'b00;
      cpuA      = 2'b00;
      cpuAddrHi = 13'h0000;
      cpuFC     = 3'h5;
      #12;
      checkOutput("reset_state", IDLE_OUT);
      @(negedge cpuClock);
      #1;
      cpuReset = 1'b0;
      repeat (2) @(posedge cpuClock);

      for (int i = 0; i < 8; i++) begin
         applyStimulus($sformatf("ram_wr_a%0d_s%0d", laneA[i], laneSize[i]), RAM_ADDR, 3'h5,
                       1'b0, laneSize[i], laneA[i], mkResp(0, 1, 0, 0, 1, 1, laneWe[i]), 0);
      end

      applyStimulus("ram_long_rd", RAM_ADDR, 3'h1, 1'b1, 2'b00, 2'b00,
                    mkResp(0, 1, 0, 0, 1, 0, 4'hF), 0);
      applyStimulus("rom_rd", ROM_ADDR, 3'h6, 1'b1, 2'b00, 2'b00,
                    mkResp(0, 1, 0, 1, 0, 0, 4'hF), 2);
`ifdef RESPONDER_BERR_EN
      applyStimulus("rom_wr", ROM_ADDR, 3'h5, 1'b0, 2'b00, 2'b00,
                    mkResp(1, 0, 1, 1, 1, 1, 4'hF), 0);
`else
      applyStimulus("rom_wr", ROM_ADDR, 3'h5, 1'b0, 2'b00, 2'b00,
                    mkResp(0, 1, 0, 1, 0, 1, 4'hF), 2);
`endif

      missCycle("miss_fc7", RAM_ADDR, 3'h7);
      missCycle("miss_window", OUT_ADDR, 3'h5);

      // Abort: AS negated while waiting on ROM, no termination may follow.
      @(negedge cpuClock);
      #1;
      driveCycle(ROM_ADDR, 3'h6, 1'b1, 2'b00, 2'b00);
      @(posedge cpuClock);
      #1;
      checkOutput("abort_wait", mkResp(1, 1, 0, 1, 0, 0, 4'hF));
      ncpuAS = 1'b1;
      ncpuDS = 1'b1;
      @(posedge cpuClock);
      #1;
      checkOutput("abort_idle", IDLE_OUT);
      repeat (4) @(posedge cpuClock);

      // Asynchronous reset in the middle of a ROM wait.
      @(negedge cpuClock);
      #1;
      driveCycle(ROM_ADDR, 3'h6, 1'b1, 2'b00, 2'b00);
      @(posedge cpuClock);
      #2;
      cpuReset = 1'b1;
      #1;
      checkOutput("reset_midwait", IDLE_OUT);
      ncpuAS = 1'b1;
      ncpuDS = 1'b1;
      @(negedge cpuClock);
      #1;
      cpuReset = 1'b0;
      @(posedge cpuClock);

      applyStimulus("post_reset_rom_rd", ROM_ADDR, 3'h6, 1'b1, 2'b00, 2'b00,
                    mkResp(0, 1, 0, 1, 0, 0, 4'hF), 2);
      applyStimulus("post_reset_ram_wr", RAM_ADDR, 3'h5, 1'b0, 2'b10, 2'b10,
                    mkResp(0, 1, 0, 0, 1, 1, 4'b1100), 0);

      repeat (3) @(posedge cpuClock);
      testsRun++;
      if (scoreboard.size() != 0) begin
         testsFailed++;
         $display("[TB] FAIL scoreboard_drain got=%0d required=0", scoreboard.size());
      end
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
